// File: rtl/ex_mdu_pkg.sv
// Shared MD encodings, default latencies and decode types for ex_mdu and the hazard unit.
package ex_mdu_pkg;

    localparam logic [5:0] OP_R        = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    localparam logic [5:0] FUNC_MADD  = 6'b000000;
    localparam logic [5:0] FUNC_MADDU = 6'b000001;
    localparam logic [5:0] FUNC_MSUB  = 6'b000100;
    localparam logic [5:0] FUNC_MSUBU = 6'b000101;

    localparam int unsigned MULT_CYCLES_DEFAULT = 5;
    localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic [0:0] {StIdle, StBusy} mdu_state_e;

    function automatic logic [63:0] ext64(input logic [31:0] v, input logic sgn);
        return {{32{sgn & v[31]}}, v};
    endfunction

endpackage

// File: rtl/ex_mdu_decode.sv
// Combinational IR -> MD op class. Accumulate ops (madd family) decode only with MDU_MADD_EN.
module ex_mdu_decode
    import ex_mdu_pkg::*;
(
    input  logic [31:0] ir,
    output logic        is_mult_type,
    output logic        is_div_type,
    output logic        is_mthi,
    output logic        is_mtlo,
    output logic        is_mfhi,
    output logic        is_mflo,
    output logic        is_signed,
    output logic        is_acc,
    output logic        is_sub
);

    logic [5:0] op;
    logic [5:0] func;
    logic       unused_ir_bits;

    assign op             = ir[31:26];
    assign func           = ir[5:0];
    assign unused_ir_bits = ^ir[25:6];

    always_comb begin
        is_mult_type = 1'b0;
        is_div_type  = 1'b0;
        is_mthi      = 1'b0;
        is_mtlo      = 1'b0;
        is_mfhi      = 1'b0;
        is_mflo      = 1'b0;
        is_signed    = 1'b0;
        is_acc       = 1'b0;
        is_sub       = 1'b0;
        if (op == OP_R) begin
            case (func)
                FUNC_MULT:  begin is_mult_type = 1'b1; is_signed = 1'b1; end
                FUNC_MULTU: is_mult_type = 1'b1;
                FUNC_DIV:   begin is_div_type = 1'b1; is_signed = 1'b1; end
                FUNC_DIVU:  is_div_type = 1'b1;
                FUNC_MFHI:  is_mfhi = 1'b1;
                FUNC_MTHI:  is_mthi = 1'b1;
                FUNC_MFLO:  is_mflo = 1'b1;
                FUNC_MTLO:  is_mtlo = 1'b1;
                default: ;
            endcase
        end
`ifdef MDU_MADD_EN
        else if (op == OP_SPECIAL2) begin
            case (func)
                FUNC_MADD:  begin is_mult_type = 1'b1; is_acc = 1'b1; is_signed = 1'b1; end
                FUNC_MADDU: begin is_mult_type = 1'b1; is_acc = 1'b1; end
                FUNC_MSUB:  begin
                    is_mult_type = 1'b1; is_acc = 1'b1; is_sub = 1'b1; is_signed = 1'b1;
                end
                FUNC_MSUBU: begin is_mult_type = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
                default: ;
            endcase
        end
`endif
    end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency multi-cycle ops.
// Optional madd/maddu/msub/msubu support via MDU_MADD_EN (see ex_mdu_decode).
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_E,
    input  logic [31:0] RS_E,
    input  logic [31:0] RT_E,
    input  logic        cancel,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic is_mult_type, is_div_type, is_mthi, is_mtlo, is_mfhi, is_mflo;
    logic is_signed, is_acc, is_sub;

    mdu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     hold_hi_q, hold_hi_d, hold_lo_q, hold_lo_d;

    logic [63:0] prod, mul_res;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, mag_q, mag_r, quo, rem;

    ex_mdu_decode u_decode (
        .ir           (IR_E),
        .is_mult_type (is_mult_type),
        .is_div_type  (is_div_type),
        .is_mthi      (is_mthi),
        .is_mtlo      (is_mtlo),
        .is_mfhi      (is_mfhi),
        .is_mflo      (is_mflo),
        .is_signed    (is_signed),
        .is_acc       (is_acc),
        .is_sub       (is_sub)
    );

    // Result is computed at the start edge and parked until the latency expires.
    always_comb begin
        prod    = ext64(RS_E, is_signed) * ext64(RT_E, is_signed);
        mul_res = prod;
        if (is_acc) begin
            mul_res = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
        end

        neg_a = is_signed & RS_E[31];
        neg_b = is_signed & RT_E[31];
        mag_a = neg_a ? (~RS_E + 32'd1) : RS_E;
        mag_b = neg_b ? (~RT_E + 32'd1) : RT_E;
        mag_q = 32'd0;
        mag_r = 32'd0;
        if (mag_b != 32'd0) begin
            mag_q = mag_a / mag_b;
            mag_r = mag_a % mag_b;
        end
        quo = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
        rem = neg_a ? (~mag_r + 32'd1) : mag_r;
        if (RT_E == 32'd0) begin
            quo = 32'hFFFF_FFFF;
            rem = RS_E;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StBusy;
            StBusy:  if (cnt_q == CntW'(1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = (state_q == StBusy);
        start   = (is_mult_type | is_div_type) & (state_q == StIdle) & ~cancel;
        HI      = hi_q;
        LO      = lo_q;
        MDU_out = 32'd0;
        if (is_mfhi) begin
            MDU_out = hi_q;
        end else if (is_mflo) begin
            MDU_out = lo_q;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hold_hi_d = hold_hi_q;
        hold_lo_d = hold_lo_q;
        if (start) begin
            cnt_d = is_div_type ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            {hold_hi_d, hold_lo_d} = is_div_type ? {rem, quo} : mul_res;
        end else if (state_q == StBusy) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                hi_d = hold_hi_q;
                lo_d = hold_lo_q;
            end
        end else if (!cancel) begin
            if (is_mthi) hi_d = RS_E;
            if (is_mtlo) lo_d = RS_E;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hold_hi_q <= 32'd0;
            hold_lo_q <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hold_hi_q <= hold_hi_d;
            hold_lo_q <= hold_lo_d;
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_ex_mdu;

    localparam logic [31:0] I_NOP   = 32'h0000_0000;
    localparam logic [31:0] I_MFHI  = 32'h0000_0010;
    localparam logic [31:0] I_MTHI  = 32'h0000_0011;
    localparam logic [31:0] I_MFLO  = 32'h0000_0012;
    localparam logic [31:0] I_MTLO  = 32'h0000_0013;
    localparam logic [31:0] I_MULT  = 32'h0000_0018;
    localparam logic [31:0] I_MULTU = 32'h0000_0019;
    localparam logic [31:0] I_DIV   = 32'h0000_001A;
    localparam logic [31:0] I_DIVU  = 32'h0000_001B;
    localparam logic [31:0] I_MADD  = 32'h7000_0000;
    localparam logic [31:0] I_MSUB  = 32'h7000_0004;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] IR_E = 32'd0;
    logic [31:0] RS_E = 32'd0;
    logic [31:0] RT_E = 32'd0;
    logic        cancel = 1'b0;
    logic        start, busy;
    logic [31:0] HI, LO, MDU_out;

    int checks = 0;
    int errors = 0;

    ex_mdu #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .IR_E    (IR_E),
        .RS_E    (RS_E),
        .RT_E    (RT_E),
        .cancel  (cancel),
        .start   (start),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO),
        .MDU_out (MDU_out)
    );

    always #5 clk = ~clk;

    // Drives one MD op for a cycle, then counts busy cycles (bounded) until idle.
    task automatic issue_md(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rt,
                            output logic saw_start, output int nb);
        @(negedge clk);
        IR_E = ir; RS_E = rs; RT_E = rt;
        #1 saw_start = start;
        @(negedge clk);
        IR_E = I_NOP;
        nb = 0;
        while (busy && nb < 200) begin
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %08h want 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %08h want 0", LO); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %0h want 0", start); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        logic s; int nb;
        issue_md(I_MULT, 32'hFFFF_FFFE, 32'd3, s, nb);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL mult_start got %0h want 1", s); end
        checks++; if (nb != 5) begin errors++; $display("FAIL mult_busy got %0d want 5", nb); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %08h want ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %08h want fffffffa", LO); end
        issue_md(I_MULTU, 32'hFFFF_FFFE, 32'd3, s, nb);
        checks++; if (HI !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %08h want 00000002", HI); end
        checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %08h want fffffffa", LO); end
    endtask

    task automatic test_div();
        logic s; int nb;
        issue_md(I_DIV, 32'd7, 32'hFFFF_FFFE, s, nb);
        checks++; if (nb != 10) begin errors++; $display("FAIL div_busy got %0d want 10", nb); end
        checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %08h want fffffffd", LO); end
        checks++; if (HI !== 32'd1) begin errors++; $display("FAIL div_hi got %08h want 1", HI); end
        issue_md(I_DIV, 32'hFFFF_FFF9, 32'd2, s, nb);
        checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divneg_lo got %08h want fffffffd", LO); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divneg_hi got %08h want ffffffff", HI); end
        issue_md(I_DIVU, 32'hFFFF_FFFF, 32'h10, s, nb);
        checks++; if (LO !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_lo got %08h want 0fffffff", LO); end
        checks++; if (HI !== 32'hF) begin errors++; $display("FAIL divu_hi got %08h want f", HI); end
    endtask

    task automatic test_div_corner();
        logic s; int nb;
        issue_md(I_DIVU, 32'd5, 32'd0, s, nb);
        checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got %08h want ffffffff", LO); end
        checks++; if (HI !== 32'd5) begin errors++; $display("FAIL divz_hi got %08h want 5", HI); end
        issue_md(I_DIV, 32'hFFFF_FFFB, 32'd0, s, nb);
        checks++; if (HI !== 32'hFFFF_FFFB) begin errors++; $display("FAIL sdivz_hi got %08h want fffffffb", HI); end
        issue_md(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s, nb);
        checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %08h want 80000000", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL divovf_hi got %08h want 0", HI); end
    endtask

    task automatic test_cancel();
        int nb;
        @(negedge clk);
        IR_E = I_MULT; RS_E = 32'd9; RT_E = 32'd9; cancel = 1'b1;
        #1;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL cancel_start got %0h want 0", start); end
        @(negedge clk);
        IR_E = I_NOP; cancel = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %0h want 0", busy); end
        checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL cancel_lo got %08h want 80000000", LO); end
        @(negedge clk);
        IR_E = I_MTHI; RS_E = 32'h1234; cancel = 1'b1;
        @(negedge clk);
        IR_E = I_NOP; cancel = 1'b0;
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL cancel_mthi got %08h want 0", HI); end
        // Cancel arriving while an op is in flight must not abort it.
        @(negedge clk);
        IR_E = I_DIVU; RS_E = 32'd100; RT_E = 32'd7;
        @(negedge clk);
        IR_E = I_NOP; cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        nb = 0;
        while (busy && nb < 200) begin nb++; @(negedge clk); end
        checks++; if (LO !== 32'd14) begin errors++; $display("FAIL inflight_lo got %08h want e", LO); end
        checks++; if (HI !== 32'd2) begin errors++; $display("FAIL inflight_hi got %08h want 2", HI); end
    endtask

    task automatic test_busy_ignore();
        int nb;
        @(negedge clk);
        IR_E = I_MULT; RS_E = 32'd6; RT_E = 32'd7;
        @(negedge clk);
        nb = 0;
        while (busy && nb < 50) begin
            nb++;
            case (nb)
                1: begin IR_E = I_DIV; RS_E = 32'd1; RT_E = 32'd1; end
                2: begin IR_E = I_MTHI; RS_E = 32'hDEAD; end
                3: begin IR_E = I_MTLO; RS_E = 32'hBEEF; end
                default: IR_E = I_NOP;
            endcase
            #1;
            checks++; if (start !== 1'b0) begin errors++; $display("FAIL busy_start n=%0d got %0h want 0", nb, start); end
            @(negedge clk);
        end
        checks++; if (nb != 5) begin errors++; $display("FAIL busy_len got %0d want 5", nb); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL busy_hi got %08h want 0", HI); end
        checks++; if (LO !== 32'd42) begin errors++; $display("FAIL busy_lo got %08h want 2a", LO); end
    endtask

    task automatic test_mtx_mfx();
        @(negedge clk);
        IR_E = I_MTLO; RS_E = 32'hABCD;
        @(negedge clk);
        IR_E = I_MFLO;
        #1;
        checks++; if (MDU_out !== 32'hABCD) begin errors++; $display("FAIL mflo got %08h want abcd", MDU_out); end
        @(negedge clk);
        IR_E = I_MTHI; RS_E = 32'h5678;
        @(negedge clk);
        IR_E = I_MFHI;
        #1;
        checks++; if (MDU_out !== 32'h5678) begin errors++; $display("FAIL mfhi got %08h want 5678", MDU_out); end
        @(negedge clk);
        IR_E = I_NOP;
        #1;
        checks++; if (MDU_out !== 32'd0) begin errors++; $display("FAIL mdu_out_idle got %08h want 0", MDU_out); end
    endtask

    task automatic test_madd();
`ifdef MDU_MADD_EN
        logic s; int nb;
        @(negedge clk);
        IR_E = I_MTHI; RS_E = 32'd0;
        @(negedge clk);
        IR_E = I_MTLO; RS_E = 32'd5;
        issue_md(I_MADD, 32'd2, 32'd3, s, nb);
        checks++; if (nb != 5) begin errors++; $display("FAIL madd_busy got %0d want 5", nb); end
        checks++; if (LO !== 32'd11) begin errors++; $display("FAIL madd_lo got %08h want b", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL madd_hi got %08h want 0", HI); end
        issue_md(I_MSUB, 32'd4, 32'd3, s, nb);
        checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL msub_lo got %08h want ffffffff", LO); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL msub_hi got %08h want ffffffff", HI); end
`else
        @(negedge clk);
        IR_E = I_MADD; RS_E = 32'd2; RT_E = 32'd3;
        #1;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL madd_off_start got %0h want 0", start); end
        @(negedge clk);
        IR_E = I_NOP;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL madd_off_busy got %0h want 0", busy); end
`endif
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        IR_E = I_DIVU; RS_E = 32'd77; RT_E = 32'd3;
        @(negedge clk);
        IR_E = I_NOP;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0h want 0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rst_mid_hi got %08h want 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL rst_mid_lo got %08h want 0", LO); end
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL rst_late_lo got %08h want 0", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL rst_late_hi got %08h want 0", HI); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_late_busy got %0h want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_cancel();
        test_busy_ignore();
        test_mtx_mfx();
        test_madd();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multiply/divide unit in the EX stage. Consumes IR_E/RS_E/RT_E straight from the ID/EX pipeline register and owns the HI/LO architectural registers.
- Runs mult/multu/div/divu over multiple cycles and services mthi/mtlo/mfhi/mflo.
- Exports start/busy to the hazard unit, which stalls MD-type instructions in D.
- Honours exception cancel from the exception/CP0 path so that a faulting or interrupted instruction never starts an operation.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); must be >=1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >=1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- IR_E  in  32  instruction in EX.
- RS_E  in  32  forwarded rs operand.
- RT_E  in  32  forwarded rt operand.
- cancel  in  1  exception/interrupt taken this cycle; suppresses start and mthi/mtlo.
- start  out  1  combinational: IR_E is mult/multu/div/divu, busy=0, cancel=0.
- busy  out  1  operation in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.
- MDU_out  out  32  HI if IR_E is mfhi, LO if mflo, else 0 (combinational).

Behaviour:
- Decode: op=IR_E[31:26]=000000 with func IR_E[5:0]:
  - mult 011000, multu 011001, div 011010, divu 011011
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
  - Any other IR_E is a no-op for this block.
- Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0, internal result regs=0. Reset mid-operation aborts it; HI/LO are not updated.
- Start edge (start=1):
  - Compute the result into hold registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; busy=1 from the next cycle.
- While busy: counter decrements each edge. On the edge where counter==1, HI/LO take the hold values and busy falls. HI/LO are visible the cycle after busy drops.
  - Total latency start->new HI/LO visible = N+1 cycles (N = 5 or 10).
- mult: {HI,LO} = signed RS*RT, 64-bit. multu: unsigned.
- div: LO = signed quotient (truncate toward zero), HI = remainder (sign of dividend). divu: unsigned.
- Divide by zero: LO=32'hFFFFFFFF, HI=dividend.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: write RS_E to HI/LO at the edge when busy=0 and cancel=0; ignored otherwise. The hazard unit prevents the busy case; the block must still ignore it.
- mfhi/mflo: MDU_out reflects the current HI/LO register value. There is no bypass of in-flight results.
- MD instruction in IR_E while busy=1: no start, no effect. The stall logic holds it until busy=0.
- cancel: blocks start and mthi/mtlo in the same cycle only. An operation already in flight completes normally (precise: it was issued before the faulting instruction).
- start and completion never coincide, because start requires busy=0.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds madd/maddu/msub/msubu, encoded op=011100 with func 000000/000001/000100/000101.
  - Each does {HI,LO} = {HI,LO} ± RS*RT (signed or unsigned) with MULT_CYCLES latency.
  - They start, busy and cancel like mult.
  - The accumulate reads HI/LO as of the start edge.
- Undefined: those encodings decode as no-op; start stays 0.

Decomposition:
- Shared package/define header holds the op/func constants above (R, SPECIAL2, mult…mtlo, madd…msubu) and the default cycle counts. The hazard unit and this block both include it.
- One natural sub-module: ex_mdu_decode, a combinational IR_E -> one-hot op class (is_mult_type, is_div_type, is_mthi, is_mtlo, is_mfhi, is_mflo, signed flag). The hazard unit reuses it.
- Counter, HI/LO and the arithmetic stay in ex_mdu.

Test Plan:
1. Reset low mid-div (counter=6) -> busy=0 immediately, HI=LO=0, no later write.
2. mult RS=0xFFFFFFFE (-2), RT=3 -> start=1 one cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
3. multu same operands -> HI=0x00000002, LO=0xFFFFFFFA; div 7/-2 -> LO=0xFFFFFFFD, HI=1; busy for 10 cycles.
4. divu 5/0 -> LO=0xFFFFFFFF, HI=5; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
5. mult with cancel=1 -> start=0, busy stays 0, HI/LO unchanged. cancel=1 while busy -> in-flight result still written. mthi 0x1234 with cancel=1 -> HI unchanged.
6. mtlo 0xABCD then mflo -> MDU_out=0xABCD next cycle. With MDU_MADD_EN, HI:LO=0:5, madd 2*3 -> LO=11 after 5 cycles.
